// File: rtl/os_types.sv
// Shared DMA types: descriptor struct, page/length limits, chunk-size helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package os_types;

    localparam int DMA_ADDR_W      = 64;
    localparam int DMA_LEN_W       = 32;
    localparam int DMA_PAGE_SIZE   = 4096;
    localparam int DMA_MAX_DSC_LEN = 4096;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_LEN_W-1:0]  len;
    } dma_dsc_t;

    typedef enum logic {
        DSC_IDLE  = 1'b0,
        DSC_ISSUE = 1'b1
    } dsc_state_t;

    // Largest chunk starting at addr: bounded by bytes left, max descriptor
    // size and distance to the next page boundary. One extra bit of width
    // so a full 2^LEN_W page/length never truncates to zero.
    function automatic logic [DMA_LEN_W:0] dsc_chunk_len(
        input logic [DMA_ADDR_W-1:0] addr,
        input logic [DMA_LEN_W:0]    remaining,
        input logic [DMA_LEN_W:0]    max_len,
        input logic [DMA_LEN_W:0]    page_size
    );
        logic [DMA_LEN_W:0] page_off;
        logic [DMA_LEN_W:0] to_page;
        logic [DMA_LEN_W:0] chunk;
        page_off = (DMA_LEN_W+1)'(addr) & (page_size - 1'b1);
        to_page  = page_size - page_off;
        chunk    = remaining;
        if (max_len < chunk) chunk = max_len;
        if (to_page < chunk) chunk = to_page;
        return chunk;
    endfunction

endpackage

// File: rtl/dma_dsc_splitter.sv
// Splits (address, length) DMA commands into page-safe, size-capped bypass descriptors.
// Latency: accept -> first descriptor 1 cycle; last transfer -> ready again 1 cycle; no bubbles between chunks.
// Backpressure: descriptor held bit-stable while dsc_byp_ready is low; no new command accepted until the current one drains.
module dma_dsc_splitter
    import os_types::*;
#(
    parameter int ADDR_WIDTH  = DMA_ADDR_W,
    parameter int LEN_WIDTH   = DMA_LEN_W,
    parameter int MAX_DSC_LEN = DMA_MAX_DSC_LEN,
    parameter int PAGE_SIZE   = DMA_PAGE_SIZE,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  pcie_clk,
    input  logic                  pcie_aresetn,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] s_cmd_address,
    input  logic [LEN_WIDTH-1:0]  s_cmd_length,
    input  logic                  dsc_byp_ready,
    output logic                  dsc_byp_load,
    output logic [ADDR_WIDTH-1:0] dsc_byp_addr,
    output logic [LEN_WIDTH-1:0]  dsc_byp_len,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  cmd_cnt,
    output logic [CNT_WIDTH-1:0]  dsc_cnt
);

    localparam int FW = DMA_LEN_W + 1;

    dsc_state_t            state;
    logic [LEN_WIDTH:0]    rem_q;      // bytes left including the descriptor on the outputs
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [LEN_WIDTH:0]    next_rem;
    logic [FW-1:0]         first_chunk;
    logic [FW-1:0]         next_chunk;
    logic                  cmd_acc;
    logic                  dsc_xfer;

    assign cmd_acc  = s_cmd_valid && s_cmd_ready;
    assign dsc_xfer = dsc_byp_load && dsc_byp_ready;

    // Chunk sizes for a fresh command and for the follow-on after the current descriptor
    always_comb begin
        next_addr   = dsc_byp_addr + ADDR_WIDTH'(dsc_byp_len);
        next_rem    = rem_q - (LEN_WIDTH+1)'(dsc_byp_len);
        first_chunk = dsc_chunk_len(DMA_ADDR_W'(s_cmd_address), FW'(s_cmd_length),
                                    FW'(MAX_DSC_LEN), FW'(PAGE_SIZE));
        next_chunk  = dsc_chunk_len(DMA_ADDR_W'(next_addr), FW'(next_rem),
                                    FW'(MAX_DSC_LEN), FW'(PAGE_SIZE));
    end

    // Command/descriptor FSM with all outputs registered
    always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            state        <= DSC_IDLE;
            s_cmd_ready  <= 1'b0;
            dsc_byp_load <= 1'b0;
            dsc_byp_addr <= '0;
            dsc_byp_len  <= '0;
            busy         <= 1'b0;
            cmd_cnt      <= '0;
            dsc_cnt      <= '0;
            rem_q        <= '0;
        end else begin
            case (state)
                DSC_IDLE: begin
                    s_cmd_ready  <= 1'b1;
                    dsc_byp_load <= 1'b0;
                    busy         <= 1'b0;
                    if (cmd_acc) begin
                        cmd_cnt <= cmd_cnt + 1'b1;
                        // Zero-length commands are counted but produce nothing
                        if (s_cmd_length != '0) begin
                            state        <= DSC_ISSUE;
                            s_cmd_ready  <= 1'b0;
                            busy         <= 1'b1;
                            dsc_byp_load <= 1'b1;
                            dsc_byp_addr <= s_cmd_address;
                            dsc_byp_len  <= LEN_WIDTH'(first_chunk);
                            rem_q        <= (LEN_WIDTH+1)'(s_cmd_length);
                        end
                    end
                end
                DSC_ISSUE: begin
                    if (dsc_xfer) begin
                        dsc_cnt <= dsc_cnt + 1'b1;
                        if (next_rem == '0) begin
                            state        <= DSC_IDLE;
                            dsc_byp_load <= 1'b0;
                            busy         <= 1'b0;
                            s_cmd_ready  <= 1'b1;
                        end else begin
                            dsc_byp_addr <= next_addr;
                            dsc_byp_len  <= LEN_WIDTH'(next_chunk);
                            rem_q        <= next_rem;
                        end
                    end
                end
                default: state <= DSC_IDLE;
            endcase
        end
    end

endmodule
